// File: rtl/sw_test_status_mon_pkg.sv
// sw_test_status_mon_pkg: channel state encoding, status codes and decode helpers
package sw_test_status_mon_pkg;

    typedef enum logic [2:0] {
        ST_UNDEF     = 3'd0,
        ST_BOOTED    = 3'd1,
        ST_IN_TEST   = 3'd2,
        ST_WFI       = 3'd3,
        ST_PASSED    = 3'd4,
        ST_FAILED    = 3'd5,
        ST_TIMED_OUT = 3'd6
    } ch_state_e;

    localparam logic [15:0] CODE_BOOTED  = 16'hb090;
    localparam logic [15:0] CODE_IN_TEST = 16'h4354;
    localparam logic [15:0] CODE_WFI     = 16'h1d1e;
    localparam logic [15:0] CODE_PASSED  = 16'h900d;
    localparam logic [15:0] CODE_FAILED  = 16'hbaad;

    localparam int unsigned LOG_OFFSET = 4;

    // Undef is never a write target, so it doubles as the "unknown code" result
    function automatic ch_state_e decode_status(input logic [15:0] d);
        case (d)
            CODE_BOOTED:  return ST_BOOTED;
            CODE_IN_TEST: return ST_IN_TEST;
            CODE_WFI:     return ST_WFI;
            CODE_PASSED:  return ST_PASSED;
            CODE_FAILED:  return ST_FAILED;
            default:      return ST_UNDEF;
        endcase
    endfunction

    function automatic logic is_terminal(input ch_state_e s);
        return s inside {ST_PASSED, ST_FAILED, ST_TIMED_OUT};
    endfunction

    function automatic logic is_active(input ch_state_e s);
        return s inside {ST_BOOTED, ST_IN_TEST, ST_WFI};
    endfunction

endpackage

// File: rtl/sw_test_status_mon_fifo.sv
// sw_test_status_mon_fifo: synchronous FIFO for log bytes; a pop frees room for a same-cycle push
module sw_test_status_mon_fifo #(
    parameter int Width = 9,
    parameter int Depth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         head_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     push_ok_o
);

    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             pop_ok;

    assign pop_ok    = pop_i && (count_o != '0);
    assign push_ok_o = push_i && ((count_o != CW'(Depth)) || pop_ok);
    assign head_o    = mem[rd_ptr];

    // storage array, no reset needed since only counted entries are ever read out
    always_ff @(posedge clk_i) begin
        if (push_ok_o) mem[wr_ptr] <= push_data_i;
    end

    // pointer and occupancy tracking
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push_ok_o) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            count_o <= count_o + CW'(push_ok_o) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/sw_test_status_mon.sv
// sw_test_status_mon: multi-channel SW test-status snooper with timeout, aggregate verdict and log FIFO
module sw_test_status_mon
    import sw_test_status_mon_pkg::*;
#(
    parameter int NumCh       = 2,
    parameter int AddrW       = 32,
    parameter int LogDepth    = 16,
    parameter int TimeoutW    = 32,
    parameter bit AbortOnFail = 1'b1,
    localparam int ChW        = (NumCh > 1) ? $clog2(NumCh) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumCh*AddrW-1:0] cfg_base_i,
    input  logic [NumCh-1:0]       cfg_en_i,
    input  logic [TimeoutW-1:0]    timeout_i,
    input  logic [NumCh-1:0]       wr_valid_i,
    input  logic [NumCh*AddrW-1:0] wr_addr_i,
    input  logic [NumCh*16-1:0]    wr_data_i,
    output logic [NumCh*3-1:0]     ch_state_o,
    output logic [NumCh-1:0]       ch_timed_out_o,
    output logic                   done_o,
    output logic                   passed_o,
    output logic                   log_valid_o,
    input  logic                   log_ready_i,
    output logic [7:0]             log_data_o,
    output logic [ChW-1:0]         log_ch_o,
    output logic                   log_drop_o
);

    logic [NumCh-1:0] term, ok, bad, log_hit;

    for (genvar i = 0; i < NumCh; i++) begin : g_ch
        ch_state_e          st_q, dec;
        logic [TimeoutW-1:0] cnt_q;
        logic               to_q, stat_hit, expire;
        logic [AddrW-1:0]   base, addr;
        assign base       = cfg_base_i[i*AddrW +: AddrW];
        assign addr       = wr_addr_i[i*AddrW +: AddrW];
        assign stat_hit   = wr_valid_i[i] && (addr == base);
        assign log_hit[i] = wr_valid_i[i] && (addr == base + AddrW'(LOG_OFFSET));
        assign dec        = decode_status(wr_data_i[i*16 +: 16]);
        assign expire     = is_active(st_q) && (timeout_i != '0) && (cnt_q == timeout_i - TimeoutW'(1));
        // channel FSM: a recognised status write beats a same-cycle timeout, terminal states hold
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                st_q  <= ST_UNDEF;
                cnt_q <= '0;
                to_q  <= 1'b0;
            end else begin
                if (is_active(st_q)) cnt_q <= cnt_q + TimeoutW'(1);
                if (!is_terminal(st_q) && stat_hit && dec != ST_UNDEF) begin
                    st_q <= dec;
                end else if (!is_terminal(st_q) && expire) begin
                    st_q <= ST_TIMED_OUT;
                    to_q <= 1'b1;
                end
            end
        end
        assign ch_state_o[i*3 +: 3] = st_q;
        assign ch_timed_out_o[i]    = to_q;
        assign term[i]              = is_terminal(st_q);
        assign ok[i]                = st_q == ST_PASSED;
        assign bad[i]               = st_q == ST_FAILED || st_q == ST_TIMED_OUT;
    end

    logic done_nxt;

    assign done_nxt = (cfg_en_i != '0) &&
                      ((&(term | ~cfg_en_i)) || (AbortOnFail && (|(bad & cfg_en_i))));

    // verdict latches on the first cycle the channel states justify it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_o   <= 1'b0;
            passed_o <= 1'b0;
        end else if (!done_o && done_nxt) begin
            done_o   <= 1'b1;
            passed_o <= &(ok | ~cfg_en_i);
        end
    end

    logic [ChW-1:0]          log_sel;
    logic [7:0]              log_byte;
    logic [ChW+7:0]          head;
    logic [$clog2(LogDepth):0] log_count;
    logic                    push, push_ok, multi;

    // lowest-indexed channel wins the single FIFO push slot
    always_comb begin
        log_sel  = '0;
        log_byte = '0;
        for (int k = NumCh - 1; k >= 0; k--) begin
            if (log_hit[k]) begin
                log_sel  = ChW'(k);
                log_byte = wr_data_i[k*16 +: 8];
            end
        end
    end

    assign push  = |log_hit;
    assign multi = (log_hit & (log_hit - NumCh'(1))) != '0;

    sw_test_status_mon_fifo #(
        .Width (ChW + 8),
        .Depth (LogDepth)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i ({log_sel, log_byte}),
        .pop_i       (log_valid_o && log_ready_i),
        .head_o      (head),
        .count_o     (log_count),
        .push_ok_o   (push_ok)
    );

    assign log_valid_o = log_count != '0;
    assign log_data_o  = log_valid_o ? head[7:0] : '0;
    assign log_ch_o    = log_valid_o ? head[ChW+7:8] : '0;

    // sticky loss flag for arbitration losers and pushes into a full FIFO
    always_ff @(posedge clk_i) begin
        if (rst_i) log_drop_o <= 1'b0;
        else if (push && (multi || !push_ok)) log_drop_o <= 1'b1;
    end

endmodule

// File: tb/tb_sw_test_status_mon.sv
// tb_sw_test_status_mon: directed self-checking bench; dut_a aborts on fail, dut_b waits for all channels
module tb_sw_test_status_mon;

    localparam logic [31:0] B0 = 32'h0000_1000;
    localparam logic [31:0] B1 = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] cfg_base = {B1, B0};
    logic [1:0]  cfg_en = 2'b11;
    logic [31:0] timeout = '0;
    logic [1:0]  wr_valid = '0;
    logic [63:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        log_ready = 1'b0;

    logic [5:0] st_a, st_b;
    logic [1:0] to_a, to_b;
    logic       done_a, done_b, passed_a, passed_b, lv_a, lv_b, ldrop_a, ldrop_b;
    logic [7:0] ld_a, ld_b;
    logic [0:0] lc_a, lc_b;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sw_test_status_mon #(.NumCh(2), .AddrW(32), .LogDepth(16), .TimeoutW(32), .AbortOnFail(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst), .cfg_base_i(cfg_base), .cfg_en_i(cfg_en), .timeout_i(timeout),
        .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .ch_state_o(st_a), .ch_timed_out_o(to_a), .done_o(done_a), .passed_o(passed_a),
        .log_valid_o(lv_a), .log_ready_i(log_ready), .log_data_o(ld_a), .log_ch_o(lc_a), .log_drop_o(ldrop_a)
    );

    sw_test_status_mon #(.NumCh(2), .AddrW(32), .LogDepth(16), .TimeoutW(32), .AbortOnFail(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .cfg_base_i(cfg_base), .cfg_en_i(cfg_en), .timeout_i(timeout),
        .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .ch_state_o(st_b), .ch_timed_out_o(to_b), .done_o(done_b), .passed_o(passed_b),
        .log_valid_o(lv_b), .log_ready_i(log_ready), .log_data_o(ld_b), .log_ch_o(lc_b), .log_drop_o(ldrop_b)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input logic [31:0] addr, input logic [15:0] data);
        wr_valid[ch] = 1'b1;
        wr_addr[ch*32 +: 32] = addr;
        wr_data[ch*16 +: 16] = data;
        step(1);
        wr_valid = '0;
    endtask

    task automatic wr2(input logic [15:0] d0, input logic [15:0] d1);
        wr_valid = 2'b11;
        wr_addr = {B1 + 32'd4, B0 + 32'd4};
        wr_data = {d1, d0};
        step(1);
        wr_valid = '0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        wr_valid = '0;
        step(1);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(2);
        n_chk++; if (st_a !== 6'd0) $display("FAIL reset_state got=%0h exp=0", st_a); else n_pass++;
        n_chk++; if (to_a !== 2'd0) $display("FAIL reset_timed_out got=%0h exp=0", to_a); else n_pass++;
        n_chk++; if ({done_a, passed_a} !== 2'b00) $display("FAIL reset_verdict got=%b exp=00", {done_a, passed_a}); else n_pass++;
        n_chk++; if ({lv_a, ldrop_a} !== 2'b00) $display("FAIL reset_log_flags got=%b exp=00", {lv_a, ldrop_a}); else n_pass++;
        n_chk++; if ({ld_a, lc_a} !== 9'd0) $display("FAIL reset_log_data got=%0h exp=0", {ld_a, lc_a}); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_pass;
        do_reset();
        wr(0, B0, 16'hb090);
        n_chk++; if (st_a[2:0] !== 3'd1) $display("FAIL pass_booted got=%0d exp=1", st_a[2:0]); else n_pass++;
        wr(0, B0, 16'h4354);
        n_chk++; if (st_a[2:0] !== 3'd2) $display("FAIL pass_in_test got=%0d exp=2", st_a[2:0]); else n_pass++;
        wr(0, B0, 16'h1d1e);
        n_chk++; if (st_a[2:0] !== 3'd3) $display("FAIL pass_wfi got=%0d exp=3", st_a[2:0]); else n_pass++;
        wr(0, B0, 16'h900d);
        n_chk++; if (st_a[2:0] !== 3'd4) $display("FAIL pass_passed got=%0d exp=4", st_a[2:0]); else n_pass++;
        wr(0, B0, 16'hbaad);
        n_chk++; if (st_a[2:0] !== 3'd4) $display("FAIL pass_terminal_hold got=%0d exp=4", st_a[2:0]); else n_pass++;
        n_chk++; if (done_a !== 1'b0) $display("FAIL pass_not_done_early got=%b exp=0", done_a); else n_pass++;
        wr(1, B1, 16'h900d);
        n_chk++; if (st_a[5:3] !== 3'd4 || done_a !== 1'b0) $display("FAIL pass_n1 got st=%0d done=%b exp st=4 done=0", st_a[5:3], done_a); else n_pass++;
        step(1);
        n_chk++; if ({done_a, passed_a} !== 2'b11) $display("FAIL pass_verdict_a got=%b exp=11", {done_a, passed_a}); else n_pass++;
        n_chk++; if ({done_b, passed_b} !== 2'b11) $display("FAIL pass_verdict_b got=%b exp=11", {done_b, passed_b}); else n_pass++;
    endtask

    task automatic test_abort;
        do_reset();
        wr(0, B0, 16'hb090);
        wr(0, B0, 16'h4354);
        wr(1, B1, 16'hbaad);
        n_chk++; if (st_a[5:3] !== 3'd5 || done_a !== 1'b0) $display("FAIL abort_n1 got st=%0d done=%b exp st=5 done=0", st_a[5:3], done_a); else n_pass++;
        step(1);
        n_chk++; if ({done_a, passed_a} !== 2'b10) $display("FAIL abort_verdict got=%b exp=10", {done_a, passed_a}); else n_pass++;
        n_chk++; if (done_b !== 1'b0) $display("FAIL noabort_waits got=%b exp=0", done_b); else n_pass++;
        wr(0, B0, 16'h900d);
        n_chk++; if (done_b !== 1'b0) $display("FAIL noabort_n1 got=%b exp=0", done_b); else n_pass++;
        step(1);
        n_chk++; if ({done_b, passed_b} !== 2'b10) $display("FAIL noabort_verdict got=%b exp=10", {done_b, passed_b}); else n_pass++;
        n_chk++; if ({done_a, passed_a} !== 2'b10) $display("FAIL abort_frozen got=%b exp=10", {done_a, passed_a}); else n_pass++;
    endtask

    task automatic test_timeout;
        cfg_en = 2'b01;
        timeout = 32'd100;
        do_reset();
        wr(0, B0, 16'hb090);
        step(99);
        n_chk++; if (st_a[2:0] !== 3'd1 || to_a[0] !== 1'b0) $display("FAIL timeout_early got st=%0d to=%b exp st=1 to=0", st_a[2:0], to_a[0]); else n_pass++;
        step(1);
        n_chk++; if (st_a[2:0] !== 3'd6) $display("FAIL timeout_state got=%0d exp=6", st_a[2:0]); else n_pass++;
        n_chk++; if (to_a[0] !== 1'b1) $display("FAIL timeout_flag got=%b exp=1", to_a[0]); else n_pass++;
        step(1);
        n_chk++; if ({done_a, passed_a, done_b, passed_b} !== 4'b1010) $display("FAIL timeout_verdict got=%b exp=1010", {done_a, passed_a, done_b, passed_b}); else n_pass++;
        do_reset();
        wr(0, B0, 16'hb090);
        step(99);
        wr(0, B0, 16'h900d);
        n_chk++; if (st_a[2:0] !== 3'd4 || to_a[0] !== 1'b0) $display("FAIL timeout_race got st=%0d to=%b exp st=4 to=0", st_a[2:0], to_a[0]); else n_pass++;
        step(1);
        n_chk++; if ({done_a, passed_a} !== 2'b11) $display("FAIL timeout_race_verdict got=%b exp=11", {done_a, passed_a}); else n_pass++;
        cfg_en = 2'b11;
        timeout = '0;
    endtask

    task automatic test_log;
        do_reset();
        log_ready = 1'b0;
        wr(0, B0 + 32'd4, 16'h004f);
        n_chk++; if (lv_a !== 1'b1 || ld_a !== 8'h4f) $display("FAIL log_first got v=%b d=%0h exp v=1 d=4f", lv_a, ld_a); else n_pass++;
        wr(0, B0 + 32'd4, 16'h004b);
        wr(0, B0 + 32'd4, 16'h000a);
        step(2);
        n_chk++; if (lv_a !== 1'b1 || ld_a !== 8'h4f || lc_a !== 1'b0) $display("FAIL log_hold got v=%b d=%0h c=%0d exp v=1 d=4f c=0", lv_a, ld_a, lc_a); else n_pass++;
        log_ready = 1'b1;
        step(1);
        n_chk++; if (ld_a !== 8'h4b) $display("FAIL log_byte2 got=%0h exp=4b", ld_a); else n_pass++;
        step(1);
        n_chk++; if (ld_a !== 8'h0a || lc_a !== 1'b0) $display("FAIL log_byte3 got d=%0h c=%0d exp d=0a c=0", ld_a, lc_a); else n_pass++;
        step(1);
        n_chk++; if (lv_a !== 1'b0 || ldrop_a !== 1'b0) $display("FAIL log_empty got v=%b drop=%b exp 0 0", lv_a, ldrop_a); else n_pass++;
        log_ready = 1'b0;
    endtask

    task automatic test_log_drop;
        logic [7:0] exp;
        do_reset();
        wr2(16'h0041, 16'h0042);
        n_chk++; if ({lv_a, ld_a, lc_a, ldrop_a} !== {1'b1, 8'h41, 1'b0, 1'b1}) $display("FAIL log_collide got v=%b d=%0h c=%0d drop=%b exp v=1 d=41 c=0 drop=1", lv_a, ld_a, lc_a, ldrop_a); else n_pass++;
        log_ready = 1'b1;
        step(1);
        n_chk++; if (lv_a !== 1'b0) $display("FAIL log_collide_single got v=%b exp=0", lv_a); else n_pass++;
        log_ready = 1'b0;
        do_reset();
        wr(1, B1 + 32'd4, 16'h0055);
        n_chk++; if ({ld_a, lc_a, ldrop_a} !== {8'h55, 1'b1, 1'b0}) $display("FAIL log_ch1 got d=%0h c=%0d drop=%b exp d=55 c=1 drop=0", ld_a, lc_a, ldrop_a); else n_pass++;
        do_reset();
        for (int i = 0; i < 16; i++) wr(0, B0 + 32'd4, 16'(i));
        n_chk++; if (ldrop_a !== 1'b0) $display("FAIL log_fill16 got drop=%b exp=0", ldrop_a); else n_pass++;
        wr(0, B0 + 32'd4, 16'h0010);
        n_chk++; if (ldrop_a !== 1'b1) $display("FAIL log_overflow got drop=%b exp=1", ldrop_a); else n_pass++;
        log_ready = 1'b1;
        wr(0, B0 + 32'd4, 16'h0020);
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? 8'(i + 1) : 8'h20;
            n_chk++; if (lv_a !== 1'b1 || ld_a !== exp) $display("FAIL log_drain_%0d got v=%b d=%0h exp v=1 d=%0h", i, lv_a, ld_a, exp); else n_pass++;
            step(1);
        end
        n_chk++; if (lv_a !== 1'b0) $display("FAIL log_drained got v=%b exp=0", lv_a); else n_pass++;
        log_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        do_reset();
        wr(0, B0, 16'h900d);
        wr(1, B1, 16'h900d);
        wr2(16'h0033, 16'h0034);
        n_chk++; if ({done_a, lv_a, ldrop_a} !== 3'b111) $display("FAIL mid_pre got=%b exp=111", {done_a, lv_a, ldrop_a}); else n_pass++;
        do_reset();
        n_chk++; if (st_a !== 6'd0 || to_a !== 2'd0) $display("FAIL mid_state got st=%0h to=%0h exp 0 0", st_a, to_a); else n_pass++;
        n_chk++; if ({done_a, passed_a, lv_a, ldrop_a} !== 4'b0000) $display("FAIL mid_flags got=%b exp=0000", {done_a, passed_a, lv_a, ldrop_a}); else n_pass++;
        n_chk++; if ({ld_a, lc_a} !== 9'd0) $display("FAIL mid_log_data got=%0h exp=0", {ld_a, lc_a}); else n_pass++;
        wr(0, B0, 16'h9999);
        n_chk++; if (st_a[2:0] !== 3'd0) $display("FAIL bad_code_undef got=%0d exp=0", st_a[2:0]); else n_pass++;
        wr(0, B0, 16'hb090);
        wr(0, B0, 16'h9999);
        n_chk++; if (st_a[2:0] !== 3'd1) $display("FAIL bad_code_booted got=%0d exp=1", st_a[2:0]); else n_pass++;
        wr(0, B0 + 32'd8, 16'h900d);
        n_chk++; if (st_a[2:0] !== 3'd1 || lv_a !== 1'b0) $display("FAIL bad_addr got st=%0d v=%b exp st=1 v=0", st_a[2:0], lv_a); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_pass();
        test_abort();
        test_timeout();
        test_log();
        test_log_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sw_test_status_mon.md
# sw_test_status_mon

Multi-channel SW test-status monitor for Verilator and DV chip benches. It snoops the write stream of up to `NumCh` simulation-SRAM windows, one per core/hart or boot stage. For each channel it tracks the software test state and enforces a per-channel cycle timeout. It aggregates a single pass/fail/done verdict for the bench's `$finish` logic, and carries a byte-wide console log channel through a shared FIFO. It supersedes the single-channel status interface, adding multi-channel aggregation, timeout and a log path.

## Interface
- `NumCh`, 2: number of snooped channels (1..8).
- `AddrW`, 32: snooped address width.
- `LogDepth`, 16: log FIFO depth; power of two, at least 2.
- `TimeoutW`, 32: timeout counter width.
- `AbortOnFail`, 1: 1 = any channel failure ends the test immediately; 0 = wait for all channels to reach a terminal state.

- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `cfg_base_i`  in  NumCh*AddrW  per-channel status address; static while out of reset. Log address is base+4.
- `cfg_en_i`  in  NumCh  channel participates in the aggregate verdict.
- `timeout_i`  in  TimeoutW  cycle budget per channel; 0 disables the timeout.
- `wr_valid_i`  in  NumCh  accepted write on the channel's window, one-cycle pulse.
- `wr_addr_i`  in  NumCh*AddrW  write address.
- `wr_data_i`  in  NumCh*16  write data, low halfword.
- `ch_state_o`  out  NumCh*3  per-channel state encoding.
- `ch_timed_out_o`  out  NumCh  sticky timeout flag.
- `done_o`  out  1  sticky test-done flag.
- `passed_o`  out  1  verdict; valid only while `done_o` is high.
- `log_valid_o`  out  1  log byte available.
- `log_ready_i`  in  1  consumer accepts the byte.
- `log_data_o`  out  8  log byte.
- `log_ch_o`  out  $clog2(NumCh) (min 1)  source channel of the log byte.
- `log_drop_o`  out  1  sticky: a log byte was lost.

## Operation
- Per-channel FSM with states Undef=0, Booted=1, InTest=2, Wfi=3, Passed=4, Failed=5, TimedOut=6.
- Status write: `wr_valid_i` with `wr_addr_i` equal to the channel's base. Data decodes as follows:
  - 0xb090 -> Booted
  - 0x4354 -> InTest
  - 0x1d1e -> Wfi
  - 0x900d -> Passed
  - 0xbaad -> Failed
  - any other value -> no change.
- Passed, Failed and TimedOut are terminal. Later status writes to a channel in a terminal state are ignored.
- Timeout counter:
  - Clears on reset and increments every cycle while the channel is in Booted, InTest or Wfi.
  - In Undef the counter is held at 0.
  - When the count reaches `timeout_i`, the channel moves to TimedOut and `ch_timed_out_o` is set.
  - A status write and timeout expiry in the same cycle: the status write wins.
- Verdict:
  - done fires when all enabled channels are terminal.
  - With `AbortOnFail`=1, done also fires as soon as any enabled channel is Failed or TimedOut.
  - `passed_o` = 1 only if every enabled channel is Passed.
  - With no channel enabled, `done_o` never asserts.
  - `done_o` and `passed_o` freeze once set, until reset.
- Log write: address equal to base+4; data bits [7:0] are pushed to the FIFO tagged with the channel index.
  - Several channels writing the log in the same cycle: the lowest index is pushed; the others are dropped and `log_drop_o` is set.
  - Push into a full FIFO: the byte is dropped and `log_drop_o` is set.
  - Push and pop in the same cycle when full: the pop happens first and the push is accepted.
- Writes matching neither address are ignored.

## Timing
- Reset values:
  - all channel states Undef, counters 0
  - `ch_timed_out_o`=0, `done_o`=0, `passed_o`=0
  - FIFO empty, `log_valid_o`=0, `log_drop_o`=0
  - `log_data_o`=0, `log_ch_o`=0.
- Status write in cycle N -> `ch_state_o` updated at the edge ending cycle N, visible in N+1.
- `done_o` and `passed_o` are registered from the state vector and rise in N+2.
- Timeout: a channel entering Booted at N times out, with state visible in N+1+`timeout_i`.
- Log path:
  - Byte written at N appears at the FIFO head with `log_valid_o`=1 in N+1.
  - Pop occurs on `log_valid_o` && `log_ready_i`.
  - `log_data_o` and `log_ch_o` are stable while `log_valid_o`=1 and `log_ready_i`=0.
- Reset asserted mid-test clears everything on the next edge, including sticky flags and FIFO contents.

## Structure
- `sw_test_status_mon_pkg` holds:
  - the `ch_state_e` enum
  - status code constants (0xb090, 0x4354, 0x1d1e, 0x900d, 0xbaad)
  - the log offset constant (4).
- Sub-module `sw_test_status_mon_fifo`: synchronous FIFO of width 8+$clog2(NumCh) with a count output. The top instantiates it once.
- Per-channel FSM and counter are a generate loop in the top.

## Test plan
- NumCh=2, both enabled, timeout 0: ch0 writes 0xb090, 0x4354, 0x900d; ch1 writes 0x900d at N -> `done_o`=1 and `passed_o`=1 in N+2.
- AbortOnFail=1: ch1 writes 0xbaad while ch0 is InTest -> `done_o`=1, `passed_o`=0, two cycles later. Repeat with AbortOnFail=0 -> done only after ch0 writes 0x900d.
- `timeout_i`=100: ch0 writes 0xb090 and nothing else -> TimedOut and `ch_timed_out_o`[0]=1 exactly 101 cycles later. Also check that a 0x900d write on the expiry cycle yields Passed.
- Log burst:
  - Write "OK\n" to base+4 on ch0 with `log_ready_i`=0 -> 3 entries held, `log_valid_o`=1.
  - Release `log_ready_i` -> bytes 0x4f, 0x4b, 0x0a in order, `log_ch_o`=0.
- Both channels write the log at the same cycle -> ch0 byte queued, `log_drop_o`=1. Filling the FIFO with 17 bytes at LogDepth=16 -> 16 stored, `log_drop_o`=1.
- After `done_o` is set, assert `rst_i` for 1 cycle -> all outputs return to reset values. A 0x9999 write and a write to base+8 -> no state change.
